// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with load extraction and writeback select
//
// Captures MEM-stage results on the rising edge (flush > stall > advance) and
// presents the register-file write port one cycle later. All wb_* outputs are
// functions of registered state only, so they settle long before the register
// file samples them on the falling edge.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   stall, flush      hold / invalidate the entry being captured
//   mem_*             MEM-stage valid, reg_write, rd, wb_sel, funct3,
//                     alu_result (also load address), pc_plus4, load_data
//   instret           retired-instruction counter (only with WB_RETIRE_CNT_EN)
//   wb_valid          WB entry valid
//   wb_reg_write      register file write enable (x0 writes suppressed)
//   wb_rd             register file destination index
//   wb_data           register file write data and forwarding value
//
// Optional feature macro: WB_RETIRE_CNT_EN (adds the 64-bit instret counter).

module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  input  logic [XLEN-1:0]       mem_load_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]           instret,
`endif
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data
);

  logic                  r_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [1:0]            r_wb_sel;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [XLEN-1:0]       r_load_data;

  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_val;
  logic [XLEN-1:0]       w_sel_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_wb_sel     <= 2'b00;
      r_funct3     <= 3'b000;
      r_alu_result <= '0;
      r_pc_plus4   <= '0;
      r_load_data  <= '0;
    end else if (flush) begin
      // Payload fields are don't-care once invalid; only the write controls
      // are cleared so nothing downstream can mistake the bubble for a write.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
    end else if (!stall) begin
      r_valid      <= mem_valid;
      r_reg_write  <= mem_reg_write;
      r_rd         <= mem_rd;
      r_wb_sel     <= mem_wb_sel;
      r_funct3     <= mem_funct3;
      r_alu_result <= mem_alu_result;
      r_pc_plus4   <= mem_pc_plus4;
      r_load_data  <= mem_load_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_instret;

  // Counts only real advances, so a stalled entry is never counted twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= 64'd0;
    end else if (!flush && !stall && mem_valid) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`endif

  // Low address bits pick the lane; halfword loads ignore bit 0.
  assign w_byte = r_load_data[{r_alu_result[1:0], 3'b000} +: 8];
  assign w_half = r_load_data[{r_alu_result[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val = r_load_data;
    case (r_funct3)
      3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_val = r_load_data;
    endcase
  end

  always_comb begin
    w_sel_data = '0;
    case (r_wb_sel)
      2'b00:   w_sel_data = r_alu_result;
      2'b01:   w_sel_data = w_load_val;
      2'b10:   w_sel_data = r_pc_plus4;
      default: w_sel_data = '0;
    endcase
  end

  assign wb_valid     = r_valid;
  assign wb_reg_write = r_valid & r_reg_write & (r_rd != '0);
  assign wb_rd        = r_rd;
  assign wb_data      = r_valid ? w_sel_data : '0;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a behavioural model

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [1:0]  mem_wb_sel = 2'b00;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [31:0] mem_alu_result = 32'd0;
  logic [31:0] mem_pc_plus4 = 32'd0;
  logic [31:0] mem_load_data = 32'd0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
  logic [63:0] m_instret;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model of the captured entry.
  logic        m_valid;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_sel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_pc, m_ld;

  // Register file driven by the DUT and its model counterpart.
  logic [31:0] rf  [32];
  logic [31:0] mrf [32];

  wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_load_data(mem_load_data),
`ifdef WB_RETIRE_CNT_EN
    .instret(instret),
`endif
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] ld);
    logic [31:0] b, h;
    b = (ld >> (8 * off)) & 32'hFF;
    h = (ld >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return ld;
    endcase
  endfunction

  function automatic logic [31:0] exp_data();
    if (!m_valid) return 32'd0;
    case (m_sel)
      2'd0: return m_alu;
      2'd1: return load_val(m_f3, m_alu[1:0], m_ld);
      2'd2: return m_pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_rw();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  always @(negedge clk) begin
    if (wb_reg_write) rf[wb_rd] = wb_data;
    if (exp_rw()) mrf[m_rd] = exp_data();
  end

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
    m_alu = 0; m_pc = 0; m_ld = 0;
`ifdef WB_RETIRE_CNT_EN
    m_instret = 64'd0;
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_rw = 0; m_rd = 0;
    end else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd; m_sel = mem_wb_sel;
      m_f3 = mem_funct3; m_alu = mem_alu_result; m_pc = mem_pc_plus4; m_ld = mem_load_data;
`ifdef WB_RETIRE_CNT_EN
      if (mem_valid) m_instret = m_instret + 64'd1;
`endif
    end
    #1;
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] ld);
    mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc; mem_load_data = ld;
  endtask

  task automatic test_reset();
    bit same;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", wb_valid); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_rw got=%0b exp=0", wb_reg_write); end
    n_cmp++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", wb_rd); end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) cycle();
    @(negedge clk); #1;
    same = 1;
    for (int i = 0; i < 32; i++) if (rf[i] !== 32'hA5A5_0000 + i) same = 0;
    n_cmp++; if (!same) begin n_fail++; $display("FAIL reset_rf_unchanged got=changed exp=unchanged"); end
  endtask

  task automatic test_alu();
    set_mem(1, 1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h44, 32'h0);
    cycle();
    n_cmp++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got=%0d exp=5", wb_rd); end
    n_cmp++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_rw got=%0b exp=1", wb_reg_write); end
    n_cmp++; if (wb_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_data got=%h exp=00001234", wb_data); end
    @(negedge clk); #1;
    n_cmp++; if (rf[5] !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_rf_x5 got=%h exp=00001234", rf[5]); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adr [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
    logic [31:0] exv [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      set_mem(1, 1, 5'd7, 2'b01, f3[i], adr[i], 32'h0, 32'h80FF_7F01);
      cycle();
      n_cmp++;
      if (wb_data !== exv[i]) begin
        n_fail++; $display("FAIL load_f3_%0d got=%h exp=%h", f3[i], wb_data, exv[i]);
      end
    end
  endtask

  task automatic test_x0_jal();
    set_mem(1, 1, 5'd0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
    cycle();
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_rw got=%0b exp=0", wb_reg_write); end
    @(negedge clk); #1;
    n_cmp++; if (rf[0] !== 32'hA5A5_0000) begin n_fail++; $display("FAIL x0_rf got=%h exp=a5a50000", rf[0]); end
    set_mem(1, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0040, 32'h0000_0100, 32'h0);
    cycle();
    n_cmp++; if (wb_data !== 32'h0000_0100) begin n_fail++; $display("FAIL jal_data got=%h exp=00000100", wb_data); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    set_mem(1, 1, 5'd9, 2'b00, 3'b000, 32'h0BAD_F00D, 32'h0, 32'h0);
    cycle();
    held_data = 32'h0BAD_F00D; held_rd = 5'd9;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_mem($urandom_range(0, 1), 1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      cycle();
      n_cmp++;
      if (wb_data !== held_data || wb_rd !== held_rd || wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold_%0d got=%h/%0d/%0b exp=%h/%0d/1", i, wb_data, wb_rd, wb_valid, held_data, held_rd);
      end
    end
    flush = 1'b1;
    cycle();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_valid got=%0b exp=0", wb_valid); end
    n_cmp++; if (wb_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_stall_rw got=%0b exp=0", wb_reg_write); end
    flush = 1'b0; stall = 1'b0;
    set_mem(1, 1, 5'd11, 2'b00, 3'b000, 32'h1357_9BDF, 32'h0, 32'h0);
    cycle();
    stall = 1'b1;
    cycle();
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall_valid got=%0b exp=0", wb_valid); end
    n_cmp++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_stall_data got=%h exp=0", wb_data); end
    #1 rst = 1'b1;
    stall = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      cycle();
      n_cmp++;
      if (wb_valid !== m_valid || wb_reg_write !== exp_rw() || wb_rd !== m_rd || wb_data !== exp_data()) begin
        n_fail++;
        $display("FAIL rand_%0d got=%0b/%0b/%0d/%h exp=%0b/%0b/%0d/%h", i, wb_valid, wb_reg_write,
                 wb_rd, wb_data, m_valid, exp_rw(), m_rd, exp_data());
      end
`ifdef WB_RETIRE_CNT_EN
      n_cmp++;
      if (instret !== m_instret) begin
        n_fail++; $display("FAIL rand_instret_%0d got=%0d exp=%0d", i, instret, m_instret);
      end
`endif
    end
    stall = 0; flush = 0;
    @(negedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (rf[i] !== mrf[i]) begin n_fail++; $display("FAIL rand_rf_x%0d got=%h exp=%h", i, rf[i], mrf[i]); end
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_instret();
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      stall = (i >= 4 && i < 7);
      flush = (i == 9 || i == 12);
      set_mem(i != 14, 1, 5'd3, 2'b00, 3'b000, $urandom, 32'h0, 32'h0);
      cycle();
    end
    stall = 0; flush = 0;
    n_cmp++; if (instret !== 64'd10) begin n_fail++; $display("FAIL instret got=%0d exp=10", instret); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'hA5A5_0000 + i;
      mrf[i] = 32'hA5A5_0000 + i;
    end
    model_reset();
    test_reset();
    test_alu();
    test_loads();
    test_x0_jal();
    test_stall_flush();
    test_random();
`ifdef WB_RETIRE_CNT_EN
    test_instret();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
